spi_responder: RTL and testbench
================================

// Module: spi_responder
// PURPOSE
// - SPI mode-0 (CPOL=0, CPHA=0) responder: the far end of our SPI initiator controller. Samples external sck/ss_n/mosi
//   in the clk domain, deserialises MOSI bytes and serialises MISO bytes from a tx byte handshake.
// - Sits between the pad ring and the responder-side read/write FIFOs.
// - Counts bytes per frame; raises spif after BLOCK_BYTES.
// PARAMETERS
// - DATA_W       8      bits per transfer unit, MSB first
// - BLOCK_BYTES  4      bytes per block; spif asserts when reached
// - SYNC_STAGES  2      synchroniser depth on sck/ss_n/mosi (>=2)
// - IDLE_FILL    8'hFF  byte shifted out when no tx data is available
// PORTS
// - clk         in   1       system clock; sck period must be >= 8 clk periods
// - reset       in   1       asynchronous, active-low reset
// - spe         in   1       enable; 0 forces IDLE
// - sck         in   1       SPI clock (async to clk)
// - ss_n        in   1       select, active low (async)
// - mosi        in   1       serial data in (async)
// - miso        out  1       serial data out
// - miso_oe     out  1       MISO pad output enable
// - tx_data     in   DATA_W  next byte to send
// - tx_valid    in   1       tx_data valid
// - tx_ready    out  1       1-cycle pulse: tx_data consumed
// - rx_data     out  DATA_W  last received byte, held until next byte
// - rx_valid    out  1       1-cycle pulse; no backpressure
// - spif        out  1       block complete, sticky within frame
// - busy        out  1       state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; miso=0, miso_oe=0, tx_ready=0, rx_data=0, rx_valid=0, spif=0, busy=0; counters 0.
// - Inputs pass SYNC_STAGES flops; edges are detected on synced values. Edge-to-action latency = SYNC_STAGES+1 clk.
// - IDLE: miso_oe=0. Synced ss_n falling with spe=1 -> LOAD; byte_cnt=0, spif=0.
// - LOAD (1 cyc): if tx_valid, tx_shift<=tx_data and tx_ready=1; else tx_shift<=IDLE_FILL. bit_cnt<=0 -> SHIFT.
// - SHIFT: miso_oe=1, miso=tx_shift[DATA_W-1].
//   - sck rise: rx_shift<={rx_shift,mosi}, bit_cnt++. On the DATA_W-th rise -> DONE.
//   - sck fall: shift tx_shift left only if bit_cnt!=0. This ignores the trailing fall of the previous byte.
// - DONE (1 cyc): rx_data<=rx_shift, rx_valid=1. byte_cnt++ saturates at BLOCK_BYTES; spif=1 when it reaches it. -> LOAD.
// - ss_n rise (synced) in any state -> IDLE. A partial byte is discarded: no rx_valid, and tx_ready does not pulse again.
//   spif holds until the next frame start.
// - spe=0 in any state -> IDLE next cycle; same outputs as reset except rx_data and spif hold.
// - tx_valid outside LOAD is ignored (held by source). A tx_valid/ss_n rise collision in LOAD: the load completes, then IDLE.
// - bit_cnt width $clog2(DATA_W)+1; byte_cnt width $clog2(BLOCK_BYTES)+1; no wrap.
// CONFIGURATION
// - SPI_RESP_UNDERRUN_EN defined: adds output tx_underrun (1b, reset 0).
//   - Set sticky when LOAD finds tx_valid=0; cleared at frame start.
// - Undefined: port absent; IDLE_FILL is sent silently.
// STRUCTURE
// - spi_pkg: typedef enum logic [1:0] {IDLE,LOAD,SHIFT,DONE} spi_resp_state_t; SPI_IDLE_FILL default constant.
// - Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse; instantiated for sck and ss_n.
//   mosi uses the synchroniser only.
// TESTING
// - Reset mid-SHIFT: drop reset after 3 bits -> all outputs at reset values; next frame byte aligned.
// - One byte: tx_data=8'hA5 valid, initiator sends 8'h3C -> MISO bits 1010_0101; rx_data=8'h3C with one rx_valid; tx_ready once.
// - 4-byte frame, tx_valid held, bytes 01,02,03,04 -> four rx_valid pulses; spif=1 after 4th DONE, 0 after next ss_n fall.
// - tx_valid=0 at LOAD -> MISO sends 8'hFF. With SPI_RESP_UNDERRUN_EN, tx_underrun=1 until next frame.
// - ss_n rises after 5 bits -> no rx_valid; IDLE within SYNC_STAGES+1 clk; miso_oe=0.
// - spe=0 mid-byte -> IDLE next cycle; sck/ss_n activity ignored until spe=1 and new ss_n fall.

Source files
------------

// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
package spi_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_resp_state_t;

    // Byte shifted out on MISO when the tx source has nothing ready.
    localparam logic [7:0] SPI_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_responder_if.sv
// SPI pad pins plus the responder-side tx/rx byte handshakes.
// Optional macro SPI_RESP_UNDERRUN_EN adds the tx_underrun status signal.
interface spi_responder_if #(
    parameter int DATA_W = 8
);
    logic              sck;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              spif;
    logic              busy;
`ifdef SPI_RESP_UNDERRUN_EN
    logic              tx_underrun;

    modport slave (
        input  sck, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, spif, busy, tx_underrun
    );
    modport master (
        output sck, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, spif, busy, tx_underrun
    );
`else
    modport slave (
        input  sck, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, spif, busy
    );
    modport master (
        output sck, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, spif, busy
    );
`endif
endinterface

// File: rtl/spi_responder_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses
// derived from the synchronised level (one clk wide each).
module spi_responder_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Shift the pin through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
            prev_r <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples sck/ss_n/mosi in the clk domain,
// deserialises MOSI bytes, serialises MISO bytes from a tx handshake and
// flags block completion (spif) once BLOCK_BYTES bytes arrive in a frame.
// Optional macro SPI_RESP_UNDERRUN_EN adds a sticky tx_underrun flag.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                BLOCK_BYTES = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = SPI_IDLE_FILL
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spe,
    spi_responder_if.slave bus
);

    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_BYTES);

    spi_resp_state_t        state_r;
    logic [DATA_W-1:0]      tx_shift_r;
    logic [DATA_W-1:0]      rx_shift_r;
    logic [DATA_W-1:0]      rx_data_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [CNT_W-1:0]       byte_cnt_r;
    logic                   miso_r;
    logic                   miso_oe_r;
    logic                   tx_ready_r;
    logic                   rx_valid_r;
    logic                   spif_r;
    logic                   busy_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   mosi_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   ss_rise_s;
    logic                   ss_fall_s;
`ifdef SPI_RESP_UNDERRUN_EN
    logic                   underrun_r;
`endif

    spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .reset(reset),
        .din  (bus.sck),
        .rise (sck_rise_s),
        .fall (sck_fall_s)
    );

    // ss_n idles high, so its synchroniser resets high to avoid a false frame start.
    spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .reset(reset),
        .din  (bus.ss_n),
        .rise (ss_rise_s),
        .fall (ss_fall_s)
    );

    // MOSI synchroniser, same depth as sck so data lines up with the sck rise pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_sync_r <= '0;
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // Responder FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            tx_shift_r <= '0;
            rx_shift_r <= '0;
            rx_data_r  <= '0;
            bit_cnt_r  <= '0;
            byte_cnt_r <= '0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
            tx_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            spif_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef SPI_RESP_UNDERRUN_EN
            underrun_r <= 1'b0;
`endif
        end else begin
            tx_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            if (!spe) begin
                // Disabled: behave as reset but keep the last byte and block flag.
                state_r    <= IDLE;
                tx_shift_r <= '0;
                rx_shift_r <= '0;
                bit_cnt_r  <= '0;
                byte_cnt_r <= '0;
                miso_r     <= 1'b0;
                miso_oe_r  <= 1'b0;
                busy_r     <= 1'b0;
`ifdef SPI_RESP_UNDERRUN_EN
                underrun_r <= 1'b0;
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        if (ss_fall_s) begin
                            state_r    <= LOAD;
                            busy_r     <= 1'b1;
                            byte_cnt_r <= '0;
                            spif_r     <= 1'b0;
`ifdef SPI_RESP_UNDERRUN_EN
                            underrun_r <= 1'b0;
`endif
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD: begin
                        // The load always completes, even if ss_n rose this cycle.
                        bit_cnt_r <= '0;
                        if (bus.tx_valid) begin
                            tx_shift_r <= bus.tx_data;
                            tx_ready_r <= 1'b1;
                            miso_r     <= bus.tx_data[DATA_W-1];
                        end else begin
                            tx_shift_r <= IDLE_FILL;
                            miso_r     <= IDLE_FILL[DATA_W-1];
`ifdef SPI_RESP_UNDERRUN_EN
                            underrun_r <= 1'b1;
`endif
                        end
                        if (ss_rise_s) begin
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                            miso_oe_r <= 1'b0;
                            miso_r    <= 1'b0;
                        end else begin
                            state_r   <= SHIFT;
                            miso_oe_r <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (ss_rise_s) begin
                            // Partial byte is dropped silently.
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                            miso_oe_r <= 1'b0;
                            miso_r    <= 1'b0;
                        end else if (sck_rise_s) begin
                            rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
                            bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
                            if (bit_cnt_r == LAST_BIT) begin
                                state_r <= DONE;
                            end
                        end else if (sck_fall_s && (bit_cnt_r != '0)) begin
                            // bit_cnt==0 means this fall trails the previous byte.
                            tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                            miso_r     <= tx_shift_r[DATA_W-2];
                        end
                    end
                    DONE: begin
                        rx_data_r  <= rx_shift_r;
                        rx_valid_r <= 1'b1;
                        if (byte_cnt_r != BLOCK_CNT) begin
                            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                            if (byte_cnt_r == (BLOCK_CNT - CNT_W'(1))) begin
                                spif_r <= 1'b1;
                            end
                        end
                        if (ss_rise_s) begin
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                            miso_oe_r <= 1'b0;
                            miso_r    <= 1'b0;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                        miso_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.miso     = miso_r;
    assign bus.miso_oe  = miso_oe_r;
    assign bus.tx_ready = tx_ready_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.spif     = spif_r;
    assign bus.busy     = busy_r;
`ifdef SPI_RESP_UNDERRUN_EN
    assign bus.tx_underrun = underrun_r;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: a mode-0 initiator drives frames,
// a queue-based model predicts MISO bytes, rx bytes, tx_ready count and
// spif; a monitor checks rx_valid/rx_data every cycle.
module tb_spi_responder;

    logic clk;
    logic reset;
    logic spe;

    spi_responder_if #(.DATA_W(8)) bus ();

    spi_responder #(
        .DATA_W     (8),
        .BLOCK_BYTES(4),
        .SYNC_STAGES(2),
        .IDLE_FILL  (8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .spe  (spe),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [7:0] src_q[$];      // what the tx source still offers
    logic [7:0] mdl_tx_q[$];   // model view of pending tx bytes
    logic [7:0] exp_rx_q[$];   // rx bytes the responder must report
    logic [7:0] mosi_pat[4];
    logic [7:0] mdl_last_rx = 8'h00;
    logic [7:0] last_miso   = 8'h00;
    logic       mdl_under   = 1'b0;
    int         mdl_frame_bytes = 0;
    int         exp_txr_cnt = 0;
    int         txr_cnt = 0;
    int         rxv_cnt = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic queue_tx(input logic [7:0] b);
        src_q.push_back(b);
        mdl_tx_q.push_back(b);
    endtask

    // A byte slot takes the next pending tx byte, otherwise the idle fill.
    task automatic take_slot(output logic [7:0] b);
        if (mdl_tx_q.size() != 0) begin
            b = mdl_tx_q.pop_front();
            exp_txr_cnt++;
        end else begin
            b = 8'hFF;
            mdl_under = 1'b1;
        end
    endtask

    // Tx source: holds tx_valid while it has data, pops on tx_ready.
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1 && src_q.size() != 0) void'(src_q.pop_front());
            if (src_q.size() != 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = src_q[0];
            end else begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'h00;
            end
        end
    end

    // Monitor: every rx_valid must match the next expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (bus.tx_ready === 1'b1) txr_cnt++;
                if (bus.rx_valid === 1'b1) begin
                    rxv_cnt++;
                    if (exp_rx_q.size() == 0) begin
                        check_eq("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("rx_data", 32'(bus.rx_data), 32'(exp_rx_q.pop_front()));
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic end_frame(input bit last_full);
        logic [7:0] dummy;
        if (last_full) take_slot(dummy);
        repeat (5) @(negedge clk);
        bus.ss_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("ss_rise_still_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_eq("ss_rise_idle_busy", 32'(bus.busy), 32'd0);
        check_eq("ss_rise_idle_oe", 32'(bus.miso_oe), 32'd0);
        check_eq("spif_hold", 32'(bus.spif), 32'(mdl_frame_bytes >= 4));
`ifdef SPI_RESP_UNDERRUN_EN
        check_eq("underrun_end", 32'(bus.tx_underrun), 32'(mdl_under));
`endif
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame(input int nfull, input int tail_bits, input bit close);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        int nslots;
        int nb;
        nb = 8;
        mdl_frame_bytes = 0;
        mdl_under = 1'b0;
        nslots = nfull + ((tail_bits > 0) ? 1 : 0);
        bus.ss_n = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("frame_spif_clr", 32'(bus.spif), 32'd0);
        check_eq("frame_busy", 32'(bus.busy), 32'd1);
        for (int b = 0; b < nslots; b++) begin
            nb = (b < nfull) ? 8 : tail_bits;
            take_slot(exp_b);
`ifdef SPI_RESP_UNDERRUN_EN
            if (b == 0) check_eq("underrun_start", 32'(bus.tx_underrun), 32'(mdl_under));
`endif
            got_b = 8'h00;
            for (int i = 0; i < nb; i++) begin
                bus.mosi = mosi_pat[b][7-i];
                if (i == 7) begin
                    exp_rx_q.push_back(mosi_pat[b]);
                    mdl_last_rx = mosi_pat[b];
                end
                repeat (5) @(negedge clk);
                got_b = {got_b[6:0], bus.miso};
                check_eq("shift_oe", 32'(bus.miso_oe), 32'd1);
                bus.sck = 1'b1;
                repeat (5) @(negedge clk);
                bus.sck = 1'b0;
            end
            last_miso = got_b;
            if (nb == 8) begin
                mdl_frame_bytes++;
                check_eq("miso_byte", 32'(got_b), 32'(exp_b));
                check_eq("spif_byte", 32'(bus.spif), 32'(mdl_frame_bytes >= 4));
            end else begin
                check_eq("miso_partial", 32'(got_b), 32'(exp_b >> (8 - nb)));
            end
        end
        if (close) end_frame(nb == 8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},     32'(bus.miso),     32'd0);
        check_eq({tag, "_miso_oe"},  32'(bus.miso_oe),  32'd0);
        check_eq({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd0);
        check_eq({tag, "_rx_data"},  32'(bus.rx_data),  32'd0);
        check_eq({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        check_eq({tag, "_spif"},     32'(bus.spif),     32'd0);
        check_eq({tag, "_busy"},     32'(bus.busy),     32'd0);
`ifdef SPI_RESP_UNDERRUN_EN
        check_eq({tag, "_underrun"}, 32'(bus.tx_underrun), 32'd0);
`endif
    endtask

    initial begin
        int txr0;
        int rxv0;
        reset    = 1'b0;
        spe      = 1'b1;
        bus.sck  = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset in the middle of a byte
        queue_tx(8'h5A);
        mosi_pat[0] = 8'hE7;
        run_frame(0, 3, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        mdl_last_rx = 8'h00;
        mdl_frame_bytes = 0;
        mdl_under = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // One byte, tx A5 / rx 3C
        txr0 = txr_cnt;
        rxv0 = rxv_cnt;
        queue_tx(8'hA5);
        mosi_pat[0] = 8'h3C;
        run_frame(1, 0, 1'b1);
        check_eq("one_miso_lit", 32'(last_miso), 32'h0000_00A5);
        check_eq("one_rx_lit", 32'(bus.rx_data), 32'h0000_003C);
        check_eq("one_txr_once", 32'(txr_cnt - txr0), 32'd1);
        check_eq("one_rxv_once", 32'(rxv_cnt - rxv0), 32'd1);

        // Four-byte block
        rxv0 = rxv_cnt;
        queue_tx(8'h11); queue_tx(8'h22); queue_tx(8'h33); queue_tx(8'h44);
        mosi_pat[0] = 8'h01; mosi_pat[1] = 8'h02; mosi_pat[2] = 8'h03; mosi_pat[3] = 8'h04;
        run_frame(4, 0, 1'b1);
        check_eq("blk_spif_lit", 32'(bus.spif), 32'd1);
        check_eq("blk_rx_lit", 32'(bus.rx_data), 32'h0000_0004);
        check_eq("blk_rxv_four", 32'(rxv_cnt - rxv0), 32'd4);

        // Underrun: nothing queued, idle fill goes out
        mosi_pat[0] = 8'h77;
        run_frame(1, 0, 1'b1);
        check_eq("under_fill_lit", 32'(last_miso), 32'h0000_00FF);
`ifdef SPI_RESP_UNDERRUN_EN
        check_eq("under_flag_lit", 32'(bus.tx_underrun), 32'd1);
`endif

        // ss_n rises after 5 bits: partial byte discarded
        rxv0 = rxv_cnt;
        queue_tx(8'h69);
        mosi_pat[0] = 8'hB4;
        run_frame(0, 5, 1'b1);
        check_eq("partial_no_rxv", 32'(rxv_cnt - rxv0), 32'd0);
        check_eq("partial_rx_hold", 32'(bus.rx_data), 32'h0000_0077);

        // spe dropped mid-byte
        queue_tx(8'h0F);
        mosi_pat[0] = 8'h5C;
        run_frame(0, 4, 1'b0);
        spe = 1'b0;
        @(negedge clk);
        check_eq("spe_busy", 32'(bus.busy), 32'd0);
        check_eq("spe_oe", 32'(bus.miso_oe), 32'd0);
        check_eq("spe_miso", 32'(bus.miso), 32'd0);
        check_eq("spe_rx_hold", 32'(bus.rx_data), 32'(mdl_last_rx));
        for (int k = 0; k < 16; k++) begin
            if (k == 8) spe = 1'b1;
            bus.sck = 1'b1;
            repeat (5) @(negedge clk);
            bus.sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        check_eq("spe_no_restart", 32'(bus.busy), 32'd0);
        bus.ss_n = 1'b1;
        repeat (6) @(negedge clk);

        // Normal frame after re-enable
        queue_tx(8'hC3);
        mosi_pat[0] = 8'h96;
        run_frame(1, 0, 1'b1);
        check_eq("post_spe_miso_lit", 32'(last_miso), 32'h0000_00C3);
        check_eq("post_spe_rx_lit", 32'(bus.rx_data), 32'h0000_0096);

        repeat (4) @(negedge clk);
        check_eq("rx_all_seen", 32'(exp_rx_q.size()), 32'd0);
        check_eq("tx_ready_count", 32'(txr_cnt), 32'(exp_txr_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
